// File: rtl/dbus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dbus_pkg
// Description : Shared types and constants for the data-memory bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package dbus_pkg;

    localparam int DBUS_BIT_WIDTH = 32;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } dbus_state_t;

    // Reserved size is folded into the misalignment class: no bus cycle either way.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        case (size)
            SZ_WORD: mis = (addr_lo != 2'b00);
            SZ_HALF: mis = addr_lo[0];
            SZ_BYTE: mis = 1'b0;
            default: mis = 1'b1;
        endcase
        is_misaligned = mis;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_bus_if_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_if_if
// Description : MEM-stage request/response bundle for the data-memory bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_bus_if_if #(
    parameter int BIT_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_write;
    logic [1:0]           req_size;
    logic                 req_signed;
    logic [BIT_WIDTH-1:0] req_addr;
    logic [BIT_WIDTH-1:0] req_wdata;
    logic                 busy;
    logic                 rsp_valid;
    logic [BIT_WIDTH-1:0] rsp_rdata;
    logic                 rsp_misalign;
    logic                 rsp_err;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  busy, rsp_valid, rsp_rdata, rsp_misalign, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output busy, rsp_valid, rsp_rdata, rsp_misalign, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/dbus_load_align.sv
`default_nettype none
// ============================================================================
// Module      : dbus_load_align
// Description : Right-justified lane extraction with optional sign extension.
// Revision    : 1.0 - initial release
// ============================================================================
module dbus_load_align
    import dbus_pkg::*;
#(
    parameter int BIT_WIDTH = DBUS_BIT_WIDTH
) (
    input  wire logic [BIT_WIDTH-1:0] i_data,
    input  wire logic [1:0]           i_size,
    input  wire logic                 i_signed,
    output logic      [BIT_WIDTH-1:0] o_data
);

    always_comb begin
        o_data = i_data;
        case (i_size)
            SZ_BYTE: o_data = {{(BIT_WIDTH-8){i_signed & i_data[7]}}, i_data[7:0]};
            SZ_HALF: o_data = {{(BIT_WIDTH-16){i_signed & i_data[15]}}, i_data[15:0]};
            default: o_data = i_data;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/dmem_bus_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_bus_if
// Description : MEM-stage to external data bus handshake (DAD/DDT/MREQ/ACKD_n).
//               Optional access timeout enabled by defining DBUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_bus_if
    import dbus_pkg::*;
#(
    parameter int BIT_WIDTH      = DBUS_BIT_WIDTH,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    dmem_bus_if_if.slave              core,
    output logic      [BIT_WIDTH-1:0] DAD,
    output logic                      MREQ,
    output logic                      WRITE,
    output logic      [1:0]           SIZE,
    input  wire logic                 ACKD_n,
    inout  wire logic [BIT_WIDTH-1:0] DDT
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_tmo_range_chk
        $error("dmem_bus_if: TIMEOUT_CYCLES must be in 1..65535");
    end

    dbus_state_t          r_state, w_state_nxt;
    logic [BIT_WIDTH-1:0] r_dad, w_dad_nxt;
    logic [1:0]           r_size, w_size_nxt;
    logic                 r_write, w_write_nxt;
    logic                 r_signed, w_signed_nxt;
    logic [BIT_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic                 r_mreq, w_mreq_nxt;
    logic [BIT_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                 r_misalign, w_misalign_nxt;
    logic [BIT_WIDTH-1:0] w_load_data;
    logic [BIT_WIDTH-1:0] w_store_lanes;
    logic                 w_tmo_hit;

    dbus_load_align #(.BIT_WIDTH(BIT_WIDTH)) u_load_align (
        .i_data   (DDT),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_data   (w_load_data)
    );

    // Zero-extension of the request data is exactly the store lane placement.
    dbus_load_align #(.BIT_WIDTH(BIT_WIDTH)) u_store_lane (
        .i_data   (core.req_wdata),
        .i_size   (core.req_size),
        .i_signed (1'b0),
        .o_data   (w_store_lanes)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_dad      <= '0;
            r_size     <= SZ_WORD;
            r_write    <= 1'b0;
            r_signed   <= 1'b0;
            r_wdata    <= '0;
            r_mreq     <= 1'b0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_dad      <= w_dad_nxt;
            r_size     <= w_size_nxt;
            r_write    <= w_write_nxt;
            r_signed   <= w_signed_nxt;
            r_wdata    <= w_wdata_nxt;
            r_mreq     <= w_mreq_nxt;
            r_rdata    <= w_rdata_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_dad_nxt      = r_dad;
        w_size_nxt     = r_size;
        w_write_nxt    = r_write;
        w_signed_nxt   = r_signed;
        w_wdata_nxt    = r_wdata;
        w_mreq_nxt     = r_mreq;
        w_rdata_nxt    = r_rdata;
        w_misalign_nxt = r_misalign;
        case (r_state)
            ST_IDLE: begin
                if (core.req_valid) begin
                    if (is_misaligned(core.req_size, core.req_addr[1:0])) begin
                        w_state_nxt    = ST_RESP;
                        w_rdata_nxt    = '0;
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt  = ST_ACCESS;
                        w_dad_nxt    = core.req_addr;
                        w_size_nxt   = core.req_size;
                        w_write_nxt  = core.req_write;
                        w_signed_nxt = core.req_signed;
                        w_wdata_nxt  = w_store_lanes;
                        w_mreq_nxt   = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                // Acknowledge takes priority over a timeout on the same edge.
                if (!ACKD_n) begin
                    w_state_nxt    = ST_RESP;
                    w_mreq_nxt     = 1'b0;
                    w_misalign_nxt = 1'b0;
                    w_rdata_nxt    = r_write ? '0 : w_load_data;
                end else if (w_tmo_hit) begin
                    w_state_nxt    = ST_RESP;
                    w_mreq_nxt     = 1'b0;
                    w_misalign_nxt = 1'b0;
                    w_rdata_nxt    = '0;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef DBUS_TIMEOUT_EN
    localparam logic [15:0] C_TMO_LIMIT = 16'(TIMEOUT_CYCLES);

    logic [15:0] r_tmo_cnt;
    logic [15:0] w_tmo_cnt_inc;
    logic        r_err;

    assign w_tmo_cnt_inc = r_tmo_cnt + 16'd1;
    assign w_tmo_hit     = (r_state == ST_ACCESS) && ACKD_n && (w_tmo_cnt_inc == C_TMO_LIMIT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo_cnt <= '0;
            r_err     <= 1'b0;
        end else begin
            if (r_state == ST_IDLE) begin
                r_tmo_cnt <= '0;
            end else if (r_state == ST_ACCESS && ACKD_n) begin
                r_tmo_cnt <= w_tmo_cnt_inc;
            end
            if (r_state != ST_RESP && w_state_nxt == ST_RESP) begin
                r_err <= (r_state == ST_ACCESS) && ACKD_n && w_tmo_hit;
            end
        end
    end

    assign core.rsp_err = r_err;
`else
    assign w_tmo_hit    = 1'b0;
    assign core.rsp_err = 1'b0;
`endif

    assign core.busy         = ((r_state == ST_IDLE) && core.req_valid) || (r_state == ST_ACCESS);
    assign core.rsp_valid    = (r_state == ST_RESP);
    assign core.rsp_rdata    = r_rdata;
    assign core.rsp_misalign = r_misalign;

    assign DAD   = r_dad;
    assign MREQ  = r_mreq;
    assign WRITE = r_write;
    assign SIZE  = r_size;
    assign DDT   = (r_mreq && r_write) ? r_wdata : {BIT_WIDTH{1'bz}};

endmodule
`default_nettype wire
